seven_seg_scan_driver: RTL
==========================

// Module: seven_seg_scan_driver
// PURPOSE
//   Feeds seven_seg_decoder and the four-digit common-anode display. Converts a binary
//   score (0..9999) to BCD with a sequential shift-add-3 converter. Time-multiplexes the
//   four digits and drives the active-low anodes.
//   'digit' always carries a value in 0..9, so the decoder never sees 10..15.
// PARAMETERS
//   SCAN_DIV  100000  clk cycles per digit slot (>=2); 100000 @100MHz = 1 kHz per digit
// PORTS
//   clk       in   1   system clock, all flops rising-edge
//   rst_n     in   1   asynchronous active-low reset
//   value     in   14  binary number to display; sampled only with load
//   load      in   1   1-cycle request to convert 'value'; ignored while busy=1
//   blank_lz  in   1   1 = blank leading zeros (units digit never blanked)
//   digit     out  4   BCD digit for the active slot -> seven_seg_decoder.digit
//   an        out  4   active-low anode enables; an[0]=units .. an[3]=thousands
//   busy      out  1   conversion in progress
//   overflow  out  1   last committed value was >9999 (display shows 9999)
// BEHAVIOUR
//   Reset (async, rst_n=0): an=4'b1111, digit=0, busy=0, overflow=0.
//     Also on reset: display regs d3..d0=0, scan counter=0, sel=0, FSM=IDLE.
//   FSM IDLE -> CONVERT -> COMMIT -> IDLE.
//   IDLE: load=1 at edge N captures src=min(value,9999) and ovf_pend=(value>9999).
//     The FSM enters CONVERT.
//   CONVERT: 14 cycles (N+1..N+14). Each cycle:
//     - add 3 to every BCD nibble >=5;
//     - then shift {bcd[15:0],src} left by 1.
//     An iteration counter of 4 bits ends the state after 14 shifts.
//   COMMIT: cycle N+15 writes d3..d0 and overflow<=ovf_pend. New digits are
//     visible on 'digit' from N+16.
//   busy=1 for cycles N+1..N+15 and is 0 at N+16; a load at N+16 is accepted.
//   load while busy=1 is dropped, with no queuing and no side effects.
//   Scan counter counts 0..SCAN_DIV-1 continuously, independent of the FSM.
//     On terminal count it wraps to 0 and sel<=sel+1 mod 4 (3 wraps to 0).
//   Outputs are registered, 1-cycle latency from sel and display regs:
//     digit<=d[sel];
//     an<=~(4'b0001<<sel), unless slot sel is blanked, then an<=4'b1111.
//   Slot i (i=1..3) is blanked when blank_lz=1 and d3..di are all zero.
//     Slot 0 is never blanked, so value 0 shows a single '0'.
//   A display update in COMMIT does not reset sel or the scan counter; the current
//     slot switches content on the next cycle.
//   Exactly one an bit is low at any time after reset, except for blanked slots.
//   Reset asserted mid-CONVERT aborts the conversion. The display returns to 0 and
//     the pending value is lost.
//   blank_lz changes take effect within 1 cycle and need no reload.
// TESTING
//   1) rst_n=0 then release, SCAN_DIV=4 -> an=1111 during reset; then an cycles
//      1110,1101,1011,0111 every 4 clk, digit=0 in each slot.
//   2) load with value=1234 -> busy high exactly 15 cycles; afterwards digit=4,3,2,1
//      while an=1110,1101,1011,0111 respectively; overflow=0.
//   3) load with value=12000 -> display 9,9,9,9, overflow=1. Next load value=5 ->
//      overflow=0.
//   4) blank_lz=1, value=7 -> only an[0] ever low, digit=7. value=0 -> only an[0]
//      low, digit=0. value=1005 -> no slot blanked.
//   5) load 42 then load 99 two cycles later (busy=1) -> 99 ignored, display shows 42,
//      busy never extends past 15 cycles.
//   6) rst_n pulsed low at cycle 7 of CONVERT -> busy=0, an=1111 during reset; after
//      release all slots show 0.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode scan driver: sequential binary-to-BCD conversion
// (shift-add-3) feeding a time-multiplexed digit/anode output stage.
module seven_seg_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        busy,
  output logic        overflow
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [13:0] MAX_VAL = 14'd9999;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  function automatic logic [13:0] sat_9999(input logic [13:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  function automatic logic [15:0] add3_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  logic [1:0]    state;
  logic [3:0]    iter;
  logic          ovf_pend;
  logic [13:0]   src_p0;
  logic [15:0]   bcd_p0;
  logic [3:0]    d [4];
  logic [CW-1:0] scan_cnt;
  logic [1:0]    sel;
  logic          blank;

  assign busy = (state != S_IDLE);

  // Slot i blanks only if it and every more-significant digit are zero.
  always_comb begin
    blank = blank_lz && (sel != 2'd0);
    for (int i = 1; i < 4; i++)
      if (2'(i) >= sel && d[i] != 4'd0) blank = 1'b0;
  end

  // Conversion datapath: {bcd, src} shifts as one 30-bit word.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && load) begin
      src_p0 <= sat_9999(value);
      bcd_p0 <= 16'd0;
    end else if (state == S_CONV) begin
      {bcd_p0, src_p0} <= {add3_adj(bcd_p0), src_p0} << 1;
    end
  end

  // Control FSM and committed display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      iter     <= 4'd0;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < 4; i++) d[i] <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            ovf_pend <= (value > MAX_VAL);
            iter     <= 4'd0;
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          iter <= iter + 4'd1;
          if (iter == 4'd13) state <= S_COMMIT;
        end
        S_COMMIT: begin
          d[3]     <= bcd_p0[15:12];
          d[2]     <= bcd_p0[11:8];
          d[1]     <= bcd_p0[7:4];
          d[0]     <= bcd_p0[3:0];
          overflow <= ovf_pend;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Free-running scan timebase and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel      <= 2'd0;
      digit    <= 4'd0;
      an       <= 4'b1111;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        sel      <= sel + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      digit <= d[sel];
      an    <= blank ? 4'b1111 : ~(4'b0001 << sel);
    end
  end

endmodule
